sa_sequencer: RTL and testbench
===============================

# sa_sequencer

Control sequencer for one ROWS x COLS systolic array of clock-gated accumulating PEs. It runs a single tile operation: preload weights, stream row-skewed feature maps, drain partial sums, then signal completion. It drives the shared PE control lines (`pe_en`, `str_en`, `mul_en`) and the read strobes of the weight and fmap buffers, and flags valid accumulator outputs at the array bottom edge.

## Interface
- `ROWS`, default 4: array rows; also the weight-preload depth and the fmap skew span.
- `COLS`, default 4: array columns; also the drain depth.
- `KW`, default 8: width of the stream-length field `k_len`.

- `clk`  in  1  clock; all PE gated clocks are derived from it.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `start`  in  1  request to begin one tile; sampled only in IDLE.
- `abort`  in  1  synchronous cancel; honoured in any non-IDLE state.
- `k_len`  in  KW  number of fmap vectors per row; latched when `start` is accepted.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  single-cycle pulse in DONE.
- `pe_en`  out  1  PE clock-gate enable.
- `str_en`  out  1  PE weight-capture strobe.
- `mul_en`  out  1  PE multiplier weight-select.
- `w_rd`  out  1  weight buffer read strobe; one word per cycle.
- `fmap_rd`  out  ROWS  per-row fmap buffer read strobes, skewed.
- `acc_vld`  out  1  bottom-edge `o_acc_kernel` values valid this cycle.
- `state`  out  3  debug encoding: IDLE=0, LOAD_W=1, STREAM=2, DRAIN=3, DONE=4.

## Operation
- FSM: IDLE -> LOAD_W -> STREAM -> DRAIN -> DONE -> IDLE.
- **IDLE.**
  - Start condition: `start`=1 and `k_len`!=0.
  - On the start condition, latch `k_len` into `k_reg` and go to LOAD_W.
  - `start` with `k_len`=0 is ignored; the FSM stays in IDLE.
- **LOAD_W.** Lasts ROWS cycles.
  - `w_rd`=1 and `pe_en`=1 on every cycle.
  - `str_en`=1 only on the last LOAD_W cycle.
  - Then go to STREAM.
- **STREAM.** Lasts `k_reg`+ROWS-1 cycles; s=0 is the first STREAM cycle.
  - `fmap_rd[r]`=1 for s in [r, r+`k_reg`-1].
  - `pe_en`=1 and `mul_en`=1 throughout.
- **DRAIN.** Lasts COLS cycles.
  - `pe_en`=1 and `mul_en`=1.
  - `fmap_rd`=0.
- **DONE.** Lasts 1 cycle.
  - `done`=1; `pe_en`, `mul_en` and `str_en` are 0.
  - Next state is IDLE.
- **`acc_vld` window.**
  - `acc_vld`=1 for s in [ROWS+COLS-1, ROWS+COLS+`k_reg`-2], counted from the first STREAM cycle (s=0).
  - The last valid cycle is the last DRAIN cycle.
- **Counters.**
  - One phase counter, cleared on each state entry. Width is clog2 of max(ROWS, 2^KW+ROWS, COLS)+1; it must not overflow at `k_len`=2^KW-1.
  - The `acc_vld` and `fmap_rd` windows come from comparing the counter against `k_reg` and the row index. No separate shift registers are needed, but they are allowed.
- **Start while busy.** `start` is ignored when not in IDLE; `k_reg` is not updated.
- **Abort.**
  - With `abort`=1 in any non-IDLE state, the next state is IDLE.
  - All outputs are 0 from that next cycle onward, and no `done` pulse is generated.
  - `abort` has priority over every other transition, including DONE -> IDLE (same result).
  - `abort` in IDLE has no effect; `start` and `abort` together in IDLE: `start` wins.

## Timing
- **Reset.** While `rst_n`=0:
  - state = IDLE, `k_reg` = 0, counter = 0.
  - All outputs are 0 (`state`=0).
  - Reset mid-operation aborts immediately and asynchronously.
- **Output registration.** All outputs are registered. Each output reflects the current state and counter and changes only on `clk` rising edges.
- **Latency from start.** `start` is sampled at edge E0, so the first LOAD_W cycle begins at E0.
- **Total length.** A tile is ROWS + (`k_reg`+ROWS-1) + COLS + 1 cycles from LOAD_W entry to the IDLE return, while `abort` stays low.
- **Back-to-back tiles.** A new `start` is accepted in the cycle after DONE, the earliest IDLE cycle. There are no additional bubble cycles.
- **`pe_en` settling.** `pe_en` is a plain flop output; the PE clock gate latches it itself. `str_en` and `mul_en` meet setup to the gated-clock edge in the same cycle.

## Test plan
- **Nominal tile.** ROWS=COLS=4, `k_len`=3, one `start` pulse:
  - LOAD_W for 4 cycles, with `str_en` only on cycle 4.
  - STREAM for 6 cycles: `fmap_rd[0]` in s=0..2, `fmap_rd[3]` in s=3..5.
  - DRAIN for 4 cycles, with `acc_vld` at s=7..9.
  - `done` pulses once, and the tile is 15 cycles in total.
- **Zero length.** `k_len`=0 with `start`=1 -> the FSM stays in IDLE, `busy`=0, and no strobes are issued.
- **Start while busy.** `start` held high for the whole tile with `k_len` changed to 5 mid-tile:
  - The running tile keeps `k_reg`=3.
  - A second tile with `k_reg`=5 begins on the cycle after `done`.
- **Abort.** Assert `abort` at STREAM s=2 -> state=0 and all outputs are 0 on the next cycle; `done` never pulses.
- **Async reset.** Assert `rst_n`=0 mid-DRAIN, between clock edges -> all outputs go to 0 immediately. After release, a fresh `start` runs a full nominal tile.
- **Maximum length.** `k_len`=255 (KW=8):
  - STREAM lasts 258 cycles and `acc_vld` is high for exactly 255 cycles.
  - No counter wrap occurs, and the tile is 267 cycles in total.

Source files
------------

// File: rtl/sa_sequencer.sv
// Tile sequencer for a ROWS x COLS systolic array: weight preload, skewed fmap
// streaming, partial-sum drain and a completion pulse. All outputs are flops.
module sa_sequencer #(
  parameter int unsigned ROWS = 4,
  parameter int unsigned COLS = 4,
  parameter int unsigned KW   = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic [KW-1:0]   k_len_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            pe_en_o,
  output logic            str_en_o,
  output logic            mul_en_o,
  output logic            w_rd_o,
  output logic [ROWS-1:0] fmap_rd_o,
  output logic            acc_vld_o,
  output logic [2:0]      state_o
);

  localparam int unsigned MAX_RC  = (ROWS > COLS) ? ROWS : COLS;
  localparam int unsigned MAX_ALL = ((2**KW + ROWS) > MAX_RC) ? (2**KW + ROWS) : MAX_RC;
  localparam int unsigned CW      = $clog2(MAX_ALL + 1);
  // Wide enough for s + k_reg and ROWS+COLS-1 without wrap.
  localparam int unsigned SW      = $clog2(2**KW + ROWS + COLS + 1) + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [KW-1:0]   k_q, k_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pe_en_q, pe_en_d;
  logic            str_en_q, str_en_d;
  logic            mul_en_q, mul_en_d;
  logic            w_rd_q, w_rd_d;
  logic [ROWS-1:0] fmap_q, fmap_d;
  logic            acc_q, acc_d;
  logic [SW-1:0]   s_nxt, k_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      k_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pe_en_q  <= 1'b0;
      str_en_q <= 1'b0;
      mul_en_q <= 1'b0;
      w_rd_q   <= 1'b0;
      fmap_q   <= '0;
      acc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      k_q      <= k_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pe_en_q  <= pe_en_d;
      str_en_q <= str_en_d;
      mul_en_q <= mul_en_d;
      w_rd_q   <= w_rd_d;
      fmap_q   <= fmap_d;
      acc_q    <= acc_d;
    end
  end

  // Next state and counter, then outputs decoded from the upcoming state so
  // each registered output describes the cycle it is visible in.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CW'(1);
    k_d      = k_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    pe_en_d  = 1'b0;
    str_en_d = 1'b0;
    mul_en_d = 1'b0;
    w_rd_d   = 1'b0;
    fmap_d   = '0;
    acc_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start_i && (k_len_i != '0)) begin
          state_d = S_LOAD_W;
          k_d     = k_len_i;
        end
      end
      S_LOAD_W: begin
        if (cnt_q == CW'(ROWS - 1)) begin
          state_d = S_STREAM;
          cnt_d   = '0;
        end
      end
      S_STREAM: begin
        if (SW'(cnt_q) + SW'(1) == SW'(k_q) + SW'(ROWS - 1)) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end
      end
      S_DRAIN: begin
        if (cnt_q == CW'(COLS - 1)) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (abort_i && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end

    s_nxt = SW'(cnt_d);
    k_nxt = SW'(k_d);

    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
    w_rd_d   = (state_d == S_LOAD_W);
    str_en_d = (state_d == S_LOAD_W) && (cnt_d == CW'(ROWS - 1));
    pe_en_d  = (state_d == S_LOAD_W) || (state_d == S_STREAM) || (state_d == S_DRAIN);
    mul_en_d = (state_d == S_STREAM) || (state_d == S_DRAIN);

    for (int r = 0; r < int'(ROWS); r++) begin
      fmap_d[r] = (state_d == S_STREAM) && (s_nxt >= SW'(r)) && (s_nxt < SW'(r) + k_nxt);
    end

    // In DRAIN the stream index is k_reg+ROWS-1+cnt, so the window test folds to cnt+k >= COLS.
    if (state_d == S_STREAM) begin
      acc_d = (s_nxt >= SW'(ROWS + COLS - 1));
    end else if (state_d == S_DRAIN) begin
      acc_d = (s_nxt + k_nxt >= SW'(COLS));
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign pe_en_o   = pe_en_q;
  assign str_en_o  = str_en_q;
  assign mul_en_o  = mul_en_q;
  assign w_rd_o    = w_rd_q;
  assign fmap_rd_o = fmap_q;
  assign acc_vld_o = acc_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_sa_sequencer.sv
// Self-checking bench for sa_sequencer against a cycle-index tile model.
module tb_sa_sequencer;

  localparam int R  = 4;
  localparam int C  = 4;
  localparam int KW = 8;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [KW-1:0] k_len;
  logic          busy, done, pe_en, str_en, mul_en, w_rd, acc_vld;
  logic [R-1:0]  fmap_rd;
  logic [2:0]    state;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: tile in flight, cycle index since LOAD_W entry, latched length.
  bit m_active = 0;
  int m_t      = 0;
  int m_k      = 0;

  int cnt_acc, cnt_done, cnt_stream, cnt_busy;

  sa_sequencer #(.ROWS(R), .COLS(C), .KW(KW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start),
    .abort_i   (abort),
    .k_len_i   (k_len),
    .busy_o    (busy),
    .done_o    (done),
    .pe_en_o   (pe_en),
    .str_en_o  (str_en),
    .mul_en_o  (mul_en),
    .w_rd_o    (w_rd),
    .fmap_rd_o (fmap_rd),
    .acc_vld_o (acc_vld),
    .state_o   (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int tile_len(input int k);
    return R + (k + R - 1) + C + 1;
  endfunction

  task automatic check_outputs();
    int s;
    logic e_busy, e_done, e_pe, e_str, e_mul, e_w, e_acc;
    logic [R-1:0] e_fm;
    logic [2:0] e_st;
    e_busy = 0; e_done = 0; e_pe = 0; e_str = 0; e_mul = 0; e_w = 0; e_acc = 0;
    e_fm = '0; e_st = 3'd0;
    if (m_active) begin
      s = m_t - R;
      e_busy = 1;
      if (m_t < R) begin
        e_st = 3'd1; e_w = 1; e_pe = 1; e_str = (m_t == R - 1);
      end else if (s < m_k + R - 1) begin
        e_st = 3'd2; e_pe = 1; e_mul = 1;
        for (int r = 0; r < R; r++) e_fm[r] = (s >= r) && (s <= r + m_k - 1);
      end else if (m_t < tile_len(m_k) - 1) begin
        e_st = 3'd3; e_pe = 1; e_mul = 1;
      end else begin
        e_st = 3'd4; e_done = 1;
      end
      if (m_t >= R) e_acc = (s >= R + C - 1) && (s <= R + C + m_k - 2);
    end
    chk("state",   32'(state),   32'(e_st));
    chk("busy",    32'(busy),    32'(e_busy));
    chk("done",    32'(done),    32'(e_done));
    chk("pe_en",   32'(pe_en),   32'(e_pe));
    chk("str_en",  32'(str_en),  32'(e_str));
    chk("mul_en",  32'(mul_en),  32'(e_mul));
    chk("w_rd",    32'(w_rd),    32'(e_w));
    chk("fmap_rd", 32'(fmap_rd), 32'(e_fm));
    chk("acc_vld", 32'(acc_vld), 32'(e_acc));
  endtask

  // One clock: inputs already driven; update the model at the edge, check #1 later.
  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      m_active = 0;
    end else if (!m_active) begin
      if (start && (k_len != 0)) begin
        m_active = 1; m_t = 0; m_k = int'(k_len);
      end
    end else if (abort) begin
      m_active = 0;
    end else begin
      m_t++;
      if (m_t == tile_len(m_k)) m_active = 0;
    end
    #1;
    check_outputs();
    cnt_acc    += int'(acc_vld);
    cnt_done   += int'(done);
    cnt_stream += int'(state == 3'd2);
    cnt_busy   += int'(busy);
  endtask

  task automatic clr_counts();
    cnt_acc = 0; cnt_done = 0; cnt_stream = 0; cnt_busy = 0;
  endtask

  // Issue a one-cycle start pulse then run until the model returns to IDLE.
  task automatic run_tile(input int k, input int budget);
    int n;
    k_len = KW'(k); start = 1; abort = 0;
    step();
    start = 0;
    n = 0;
    while (m_active && n < budget) begin
      step();
      n++;
    end
    chk("tile_timeout", 32'(busy), 32'(0));
  endtask

  initial begin
    rst_n = 0; start = 0; abort = 0; k_len = '0;
    clr_counts();
    #2;
    check_outputs();
    step();
    step();
    #2 rst_n = 1;
    step();

    // Nominal tile, k=3.
    clr_counts();
    run_tile(3, 50);
    chk("nom_len",    32'(cnt_busy),   32'(15));
    chk("nom_acc",    32'(cnt_acc),    32'(3));
    chk("nom_done",   32'(cnt_done),   32'(1));
    chk("nom_stream", 32'(cnt_stream), 32'(6));

    // Zero length start is ignored.
    clr_counts();
    k_len = '0; start = 1;
    repeat (4) step();
    start = 0;
    chk("zero_busy", 32'(cnt_busy), 32'(0));

    // Start held through a tile while k_len changes; back-to-back second tile.
    clr_counts();
    k_len = 8'd3; start = 1;
    step();
    repeat (5) step();
    k_len = 8'd5;
    while (m_active) step();
    chk("b2b_first_len", 32'(cnt_busy), 32'(15));
    step();
    start = 0;
    chk("b2b_second_state", 32'(state), 32'(1));
    clr_counts();
    while (m_active) step();
    chk("b2b_second_len", 32'(cnt_busy + 1), 32'(tile_len(5)));
    chk("b2b_second_acc", 32'(cnt_acc), 32'(5));

    // Abort at STREAM s=2.
    clr_counts();
    k_len = 8'd3; start = 1;
    step();
    start = 0;
    while (m_t < R + 2) step();
    abort = 1;
    step();
    abort = 0;
    chk("abort_state", 32'(state), 32'(0));
    repeat (3) step();
    chk("abort_done", 32'(cnt_done), 32'(0));

    // Asynchronous reset in DRAIN, between edges.
    k_len = 8'd3; start = 1;
    step();
    start = 0;
    while (m_t < R + (3 + R - 1) + 1) step();
    chk("pre_rst_state", 32'(state), 32'(3));
    #3 rst_n = 0;
    #1;
    m_active = 0;
    check_outputs();
    step();
    #2 rst_n = 1;
    step();
    clr_counts();
    run_tile(3, 50);
    chk("post_rst_len", 32'(cnt_busy), 32'(15));

    // Maximum length.
    clr_counts();
    run_tile(255, 400);
    chk("max_stream", 32'(cnt_stream), 32'(258));
    chk("max_acc",    32'(cnt_acc),    32'(255));
    chk("max_len",    32'(cnt_busy),   32'(267));

    // Random tiles with stray starts, k_len changes and occasional aborts.
    for (int i = 0; i < 30; i++) begin
      int n;
      k_len = KW'($urandom_range(0, 12));
      start = 1;
      abort = ($urandom_range(0, 7) == 0);
      step();
      n = 0;
      while (m_active && n < 100) begin
        start = ($urandom_range(0, 3) == 0);
        k_len = KW'($urandom_range(0, 20));
        abort = ($urandom_range(0, 40) == 0);
        step();
        n++;
      end
      start = 0; abort = 0;
      step();
      chk("rand_idle", 32'(busy), 32'(m_active));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
